// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 16;
  localparam int unsigned FETCH_INSTR_W = 16;

  localparam logic [FETCH_ADDR_W-1:0]  FETCH_RESET_PC = 16'h0000;
  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR      = 16'h0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with show-ahead head, push/pop and flush.
// Flush takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t            mem_q [Depth];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]           count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous ROM and buffers
// returned instructions. Optional perf counters are enabled with FETCH_PERF_EN.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [INSTR_W-1:0]     rom_q,
  output logic [INSTR_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]      pc_out,
  output logic                   instr_valid,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            perf_stall_cycles,
  output logic [15:0]            perf_redirects
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_v_q, req_v_d;
  logic [CntW:0]     credit;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Entries held plus the read in flight must never exceed the FIFO capacity.
  assign credit = {1'b0, fifo_count} + {{CntW{1'b0}}, req_v_q};
  assign issue  = !redirect && (credit < (CntW+1)'(DEPTH));
  assign push   = req_v_q && !redirect;
  assign pop    = instr_valid && !stall;

  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = rom_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_v_d    = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      req_v_d    = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      req_v_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_v_q    <= req_v_d;
    end
  end

  fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign rom_address = fetch_pc_q;
  assign instr_valid = (fifo_count != '0);
  assign instr_out   = instr_valid ? head.instr : NOP_INSTR;
  assign pc_out      = instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_q;
  logic [15:0] perf_redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (stall && instr_valid && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
      if (redirect && (perf_redir_q != 16'hFFFF)) perf_redir_q <= perf_redir_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule
